// File: rtl/tcdm_mux_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_mux_pkg
// Shared types and helpers for the TCDM round-robin request multiplexer.
//   id_width(n) : bits needed to hold an index 0..n-1 (at least 1)
//   tcdm_req_t  : request payload carried from the winning master to memory
// -----------------------------------------------------------------------------
package tcdm_mux_pkg;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [3:0]  be;
      logic [31:0] data;
   } tcdm_req_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_tcdm
// TCDM request/response bundle.
//   req/gnt             : request handshake (accepted on req & gnt)
//   add/wen/be/data     : request payload (wen=1 read, wen=0 write)
//   r_valid/r_data      : one response per accepted request, in order
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_tcdm;
   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] data;
   logic [31:0] r_data;
   logic        r_valid;

   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_id_fifo.sv
// -----------------------------------------------------------------------------
// tcdm_id_fifo
// Small FIFO holding the master index of every granted, not yet answered
// transaction. Head is visible combinationally (fall-through read).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : enqueue data_i (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   data_i        : entry to enqueue
//   data_o        : current head entry
//   full_o        : DEPTH entries stored
//   empty_o       : no entries stored
//   count_o       : current occupancy
// -----------------------------------------------------------------------------
module tcdm_id_fifo
   import tcdm_mux_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic [WIDTH-1:0]               data_i,
   output logic [WIDTH-1:0]               data_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned PTR_W = id_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      // simultaneous push and pop leaves occupancy unchanged
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage carries no reset: an entry is only read after it was written
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/tcdm_rr_mux.sv
// -----------------------------------------------------------------------------
// tcdm_rr_mux
// N-to-1 TCDM request multiplexer with round-robin arbitration and in-order
// response routing through an outstanding-ID FIFO.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   in_tcdm[NB_IN] : master-side ports
//   out_tcdm       : single port towards memory
//   busy_o         : at least one transaction outstanding
//   outstanding_o  : number of granted, unanswered transactions
// -----------------------------------------------------------------------------
module tcdm_rr_mux
   import tcdm_mux_pkg::*;
#(
   parameter int unsigned NB_IN           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   hwpe_stream_intf_tcdm.slave                    in_tcdm [NB_IN],
   hwpe_stream_intf_tcdm.master                   out_tcdm,
   output logic                                   busy_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

   localparam int unsigned ID_W  = id_width(NB_IN);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ID_W:0]   NB_IN_EXT = (ID_W + 1)'(NB_IN);
   localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NB_IN - 1);

   logic [NB_IN-1:0] req_vec;
   tcdm_req_t        in_req [NB_IN];
   tcdm_req_t        win_req;
   logic             win_valid;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W:0]    scan_cand;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic             out_req;
   logic             hs;
   logic             rsp_ok;
   logic             fifo_full, fifo_empty;
   logic [ID_W-1:0]  head_id;
   logic [CNT_W-1:0] fifo_count;

   for (genvar gi = 0; gi < NB_IN; gi++) begin : g_in
      assign req_vec[gi] = in_tcdm[gi].req;
      assign in_req[gi]  = '{add:  in_tcdm[gi].add,
                             wen:  in_tcdm[gi].wen,
                             be:   in_tcdm[gi].be,
                             data: in_tcdm[gi].data};
   end

   // first requester at or after rr_q, wrapping modulo NB_IN
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      scan_cand = '0;
      for (int k = 0; k < NB_IN; k++) begin
         scan_cand = {1'b0, rr_q} + (ID_W + 1)'(k);
         if (scan_cand >= NB_IN_EXT) begin
            scan_cand = scan_cand - NB_IN_EXT;
         end
         if (!win_valid && req_vec[scan_cand[ID_W-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = scan_cand[ID_W-1:0];
         end
      end
   end

   assign win_req = win_valid ? in_req[win_idx] : '0;

   // a full ID FIFO holds the request off so a grant can never be lost
   assign out_req       = win_valid && !fifo_full;
   assign out_tcdm.req  = out_req;
   assign out_tcdm.add  = win_req.add;
   assign out_tcdm.wen  = win_req.wen;
   assign out_tcdm.be   = win_req.be;
   assign out_tcdm.data = win_req.data;

   assign hs = out_req && out_tcdm.gnt;

   always_comb begin
      rr_d = rr_q;
      if (hs) begin
         rr_d = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // a response with nothing outstanding is dropped
   assign rsp_ok = out_tcdm.r_valid && !fifo_empty;

   tcdm_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (ID_W)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs),
      .pop_i   (rsp_ok),
      .data_i  (win_idx),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   for (genvar gi = 0; gi < NB_IN; gi++) begin : g_out
      assign in_tcdm[gi].gnt     = hs && (win_idx == ID_W'(gi));
      assign in_tcdm[gi].r_valid = rsp_ok && (head_id == ID_W'(gi));
      assign in_tcdm[gi].r_data  = (rsp_ok && (head_id == ID_W'(gi))) ? out_tcdm.r_data : '0;
   end

   assign busy_o        = (fifo_count != '0);
   assign outstanding_o = fifo_count;

   a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(out_tcdm.r_valid && fifo_empty));

endmodule

// File: tb/tb_tcdm_rr_mux.sv
module tb_tcdm_rr_mux;

   localparam int NB   = 4;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   hwpe_stream_intf_tcdm in_if [NB] ();
   hwpe_stream_intf_tcdm out_if ();

   logic        busy;
   logic [1:0]  outstanding;

   logic [NB-1:0] m_req;
   logic [31:0]   m_add  [NB];
   logic          m_wen  [NB];
   logic [3:0]    m_be   [NB];
   logic [31:0]   m_data [NB];
   logic [NB-1:0] p_gnt, p_rvalid;
   logic [31:0]   p_rdata [NB];

   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   for (genvar gi = 0; gi < NB; gi++) begin : g_bridge
      assign in_if[gi].req  = m_req[gi];
      assign in_if[gi].add  = m_add[gi];
      assign in_if[gi].wen  = m_wen[gi];
      assign in_if[gi].be   = m_be[gi];
      assign in_if[gi].data = m_data[gi];
      assign p_gnt[gi]      = in_if[gi].gnt;
      assign p_rvalid[gi]   = in_if[gi].r_valid;
      assign p_rdata[gi]    = in_if[gi].r_data;
   end

   assign out_if.gnt     = mem_gnt;
   assign out_if.r_valid = mem_rvalid;
   assign out_if.r_data  = mem_rdata;

   tcdm_rr_mux #(
      .NB_IN           (NB),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .in_tcdm       (in_if),
      .out_tcdm      (out_if),
      .busy_o        (busy),
      .outstanding_o (outstanding)
   );

   // reference model: issue-order scoreboard, timed memory, plain RR pointer
   typedef struct { int master; logic [31:0] data; } issue_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;
   issue_t      issue_q [$];
   rsp_t        rsp_q [$];
   logic [31:0] mem_model [logic [31:0]];
   int          grant_log [$];

   int checks = 0, failures = 0;
   int cyc = 0, last_due = 0, rr_model = 0;
   int gnt_pct = 100, lat_min = 1, lat_max = 1, rand_pct = 0;
   logic [NB-1:0] reissue_mask = '0;
   int          rsp_cnt [NB];
   logic [31:0] last_rdata [NB];
   int blocked_cnt = 0, overlap_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : 32'h0;
   endfunction

   task automatic set_req(input int m, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
      m_req[m] = 1'b1; m_add[m] = a; m_wen[m] = w; m_be[m] = b; m_data[m] = d;
   endtask

   task automatic new_req(input int m);
      logic [31:0] a;
      a = 32'($urandom_range(7)) << 2;
      set_req(m, a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
   endtask

   task automatic do_cycle();
      int w, granted, due;
      logic any, exp_oreq, exp_hs;
      int head;
      logic [31:0] rd, cur;
      mem_gnt = ($urandom_range(99) < gnt_pct);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         mem_rvalid = 1'b1; mem_rdata = rsp_q[0].data;
      end else begin
         mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
      @(negedge clk);
      any = |m_req;
      w = -1;
      for (int k = 0; k < NB; k++) begin
         if (w < 0 && m_req[(rr_model + k) % NB]) w = (rr_model + k) % NB;
      end
      exp_oreq = any && (issue_q.size() < MAXO);
      chk($sformatf("out_req c%0d", cyc), out_if.req, exp_oreq);
      chk($sformatf("out_add c%0d", cyc), out_if.add, any ? m_add[w] : 32'h0);
      chk($sformatf("out_wen c%0d", cyc), out_if.wen, any ? m_wen[w] : 1'b0);
      chk($sformatf("out_be c%0d", cyc), out_if.be, any ? m_be[w] : 4'h0);
      chk($sformatf("out_data c%0d", cyc), out_if.data, any ? m_data[w] : 32'h0);
      exp_hs = exp_oreq && mem_gnt;
      head = mem_rvalid ? issue_q[0].master : -1;
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("gnt%0d c%0d", i, cyc), p_gnt[i], exp_hs && (i == w));
         chk($sformatf("rvalid%0d c%0d", i, cyc), p_rvalid[i], i == head);
         chk($sformatf("rdata%0d c%0d", i, cyc), p_rdata[i], (i == head) ? issue_q[0].data : 32'h0);
         if (p_rvalid[i]) begin
            rsp_cnt[i]++;
            last_rdata[i] = p_rdata[i];
         end
      end
      chk($sformatf("outstanding c%0d", cyc), outstanding, issue_q.size());
      chk($sformatf("busy c%0d", cyc), busy, issue_q.size() != 0);
      if (any && !exp_oreq) blocked_cnt++;
      if (exp_hs && mem_rvalid) overlap_cnt++;
      if (mem_rvalid) begin
         void'(rsp_q.pop_front());
         void'(issue_q.pop_front());
      end
      granted = -1;
      if (exp_hs) begin
         granted = w;
         grant_log.push_back(w);
         rd = mem_rd(m_add[w]);
         if (!m_wen[w]) begin
            cur = rd;
            for (int b = 0; b < 4; b++) if (m_be[w][b]) cur[8*b +: 8] = m_data[w][8*b +: 8];
            mem_model[m_add[w]] = cur;
         end
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rsp_q.push_back('{due, rd});
         issue_q.push_back('{w, rd});
         rr_model = (w + 1) % NB;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (granted >= 0) begin
         m_req[granted] = 1'b0;
         if (reissue_mask[granted]) new_req(granted);
      end
      for (int i = 0; i < NB; i++) begin
         if (!m_req[i] && $urandom_range(99) < rand_pct) new_req(i);
         else if (m_req[i] && rand_pct > 0 && $urandom_range(99) < 5) m_data[i] = $urandom;
      end
   endtask

   task automatic run_until_idle(input int bound);
      for (int n = 0; n < bound && (m_req != '0 || issue_q.size() > 0); n++) do_cycle();
      chk("idle_timeout", (m_req != '0 || issue_q.size() > 0), 1'b0);
   endtask

   task automatic do_reset();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_outstanding", outstanding, 2'd0);
      chk("rst_gnt", p_gnt, '0);
      chk("rst_rvalid", p_rvalid, '0);
      for (int i = 0; i < NB; i++) chk($sformatf("rst_rdata%0d", i), p_rdata[i], 32'h0);
      chk("rst_out_req", out_if.req, |m_req);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      issue_q.delete(); rsp_q.delete(); grant_log.delete();
      rr_model = 0;
   endtask

   initial begin
      m_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      for (int i = 0; i < NB; i++) begin
         set_req(i, 32'h0, 1'b0, 4'h0, 32'h0);
         rsp_cnt[i] = 0; last_rdata[i] = 32'h0;
      end
      m_req = '0;
      @(posedge clk);
      #1;
      do_reset();

      // single master: write then read back on port 2
      set_req(2, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
      run_until_idle(20);
      set_req(2, 32'h10, 1'b1, 4'hF, 32'h0);
      run_until_idle(20);
      chk("single_rsp2", rsp_cnt[2], 2);
      chk("single_rsp0", rsp_cnt[0], 0);
      chk("single_rsp1", rsp_cnt[1], 0);
      chk("single_rsp3", rsp_cnt[3], 0);
      chk("single_rdata", last_rdata[2], 32'hDEADBEEF);
      chk("single_grants", grant_log.size(), 2);
      $display("phase single: %0d grants", grant_log.size());

      // fairness from reset with all masters requesting
      do_reset();
      for (int i = 0; i < NB; i++) new_req(i);
      reissue_mask = '1;
      overlap_cnt = 0;
      for (int n = 0; n < 60 && grant_log.size() < 8; n++) do_cycle();
      reissue_mask = '0;
      m_req = '0;
      run_until_idle(20);
      chk("fair_cnt_ok", grant_log.size() >= 8, 1'b1);
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         chk($sformatf("fair_order%0d", k), grant_log[k], k % NB);
      chk("overlap_seen", overlap_cnt > 0, 1'b1);
      $display("phase fairness: %0d grants", grant_log.size());

      // wrap and skip: park pointer at 3, then only masters 1 and 3
      new_req(2);
      run_until_idle(20);
      grant_log.delete();
      new_req(1); new_req(3);
      reissue_mask = 4'b1010;
      for (int n = 0; n < 30 && grant_log.size() < 3; n++) do_cycle();
      reissue_mask = '0;
      m_req = '0;
      run_until_idle(20);
      chk("wrap_cnt_ok", grant_log.size() >= 3, 1'b1);
      if (grant_log.size() >= 3) begin
         chk("wrap_g0", grant_log[0], 3);
         chk("wrap_g1", grant_log[1], 1);
         chk("wrap_g2", grant_log[2], 3);
      end
      $display("phase wrap: %0d grants", grant_log.size());

      // backpressure with 4-cycle memory latency
      lat_min = 4; lat_max = 4;
      blocked_cnt = 0;
      new_req(0); new_req(1); new_req(2);
      run_until_idle(40);
      chk("bp_blocked_seen", blocked_cnt > 0, 1'b1);
      $display("phase backpressure: blocked %0d cycles", blocked_cnt);

      // reset with two transactions outstanding
      new_req(0); new_req(1);
      do_cycle();
      do_cycle();
      chk("mid_outstanding", outstanding, 2'd2);
      for (int i = 0; i < NB; i++) new_req(i);
      do_reset();
      lat_min = 1; lat_max = 1;
      for (int n = 0; n < 10 && grant_log.size() < 1; n++) do_cycle();
      chk("mid_first_ok", grant_log.size() >= 1, 1'b1);
      if (grant_log.size() >= 1) chk("mid_first_winner", grant_log[0], 0);
      m_req = '0;
      run_until_idle(20);
      $display("phase reset: first winner after release checked");

      // random traffic
      gnt_pct = 70; lat_min = 1; lat_max = 4; rand_pct = 30;
      for (int n = 0; n < 400; n++) do_cycle();
      rand_pct = 0;
      run_until_idle(200);
      $display("phase random: cycle %0d", cyc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tcdm_rr_mux.md
Name: tcdm_rr_mux

Overview:
- N-to-1 TCDM request multiplexer placed directly upstream of the single-port TCDM memory model.
- Several accelerator or testbench masters share one memory port.
- Round-robin arbitration on the request path.
- In-order response routing via an outstanding-ID FIFO, so every r_valid/r_data returns to the master that issued the transaction.

Parameters:
- NB_IN, 4, number of upstream master ports (>=2; non-power-of-2 allowed).
- MAX_OUTSTANDING, 2, ID FIFO depth = max granted-but-unanswered transactions (>=1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_tcdm  slave  hwpe_stream_intf_tcdm[NB_IN]  master-side ports (req, gnt, add[31:0], wen, be[3:0], data[31:0], r_data[31:0], r_valid).
- out_tcdm  master  hwpe_stream_intf_tcdm  port to memory.
- busy_o  output  1  high while any transaction is outstanding.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.

Behaviour:
- Protocol: wen=1 read, wen=0 write. A transaction is accepted on req&gnt. The memory returns exactly one r_valid per accepted transaction, reads and writes alike, in order, at a fixed or variable latency of at least 1 cycle.
- Reset values:
  - rr_q=0, FIFO empty, busy_o=0, outstanding_o=0.
  - All in_tcdm gnt/r_valid=0, r_data=0.
  - out_tcdm.req=0 whenever no master requests.
- Arbitration (combinational, 0 added latency):
  - Winner = first requesting index scanning rr_q, rr_q+1, ... with wrap mod NB_IN.
  - out_tcdm.req = (any in req) & ~fifo_full.
  - add/wen/be/data are forwarded from the winner; these signals are 0 when there is no winner.
- Grant: in_tcdm[w].gnt = out_tcdm.gnt & out_tcdm.req, asserted for the winner only. All other gnt=0.
- Pointer update on an accepted handshake: rr_q <= (w==NB_IN-1) ? 0 : w+1. rr_q holds when there is no handshake.
- Masters keep req and payload stable until gnt. The mux tolerates a master changing payload without gnt and never latches it.
- ID FIFO:
  - Push winner index on out handshake.
  - Pop on out_tcdm.r_valid.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Full: out_tcdm.req forced 0 and no gnt, so no push at full. Pop at full is allowed.
  - Pointers wrap mod MAX_OUTSTANDING.
- Response routing (combinational, 0 added latency):
  - in_tcdm[head].r_valid = out_tcdm.r_valid, in_tcdm[head].r_data = out_tcdm.r_data.
  - Non-head ports: r_valid=0, r_data=0.
- r_valid with FIFO empty: protocol error. Flag it with a simulation assertion, drop the response, and leave state unchanged.
- busy_o = occupancy!=0; outstanding_o = occupancy (registered state, not a combinational sum).
- Reset mid-operation: FIFO and rr_q clear immediately (async). Outstanding responses arriving after reset are dropped per the empty rule.

Decomposition:
- Package tcdm_mux_pkg holds:
  - localparam function id_width(n) = (n>1)?$clog2(n):1.
  - typedef tcdm_req_t {add, wen, be, data}, used for the internal winner mux.
- One sub-module: tcdm_id_fifo.
  - Parameterised DEPTH, WIDTH.
  - Ports push_i, pop_i, data_i, data_o, full_o, empty_o, count_o.
  - Async active-low reset.
  - Fall-through read of head.

Test Plan:
- Single master: master 2 writes 0xDEADBEEF to 0x10 (be=4'hF), then reads 0x10. Expect:
  - gnt same cycle as req.
  - Two r_valid pulses on port 2 only; read r_data=0xDEADBEEF.
  - Ports 0, 1, 3 r_valid and r_data stay 0.
- Fairness: all 4 masters hold req continuously for 8 accepted handshakes from reset. Expect grant order 0,1,2,3,0,1,2,3 and each master's responses in issue order.
- Wrap and skip: rr_q=3 with only masters 1 and 3 requesting. Expect grant to 3, then 1, then 3.
- Backpressure: MAX_OUTSTANDING=2 and memory response latency stretched to 4 cycles. Expect:
  - Third request sees out_tcdm.req=0 and no gnt until the first r_valid.
  - outstanding_o goes 1, 2, 2, ..., then 1.
  - No lost or misrouted responses.
- Simultaneous push and pop: a new grant lands in the same cycle as a response. Expect occupancy unchanged and the response routed to the older ID, not the new winner.
- Reset mid-flight: assert rst_ni=0 with 2 outstanding. Expect:
  - Immediately busy_o=0, outstanding_o=0, all gnt/r_valid=0.
  - After release, rr_q=0 (master 0 wins the first contention).
  - A stale r_valid is dropped and the assertion fires.
